// File: rtl/ddsm_fs4_duc_if.sv
// ddsm_fs4_duc_if: sample bus between the I/Q delta-sigma modulators, the
// fs/4 up-converter and the RF DAC/PA driver.
//   in_valid/in_i/in_q : signed I/Q DDSM words, one pair per valid cycle
//   sync               : reload the mixer phase counter
//   mode               : 00 mix, 01 I passthrough, 10 tone, 11 mute
//   out_data/out_valid/out_phase : up-converted real stream
// master drives the inputs (modulator side); slave is the up-converter.
interface ddsm_fs4_duc_if #(
  parameter int DW = 6
);
  logic          in_valid;
  logic [DW-1:0] in_i;
  logic [DW-1:0] in_q;
  logic          sync;
  logic [1:0]    mode;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [1:0]    out_phase;

  modport master (
    output in_valid, in_i, in_q, sync, mode,
    input  out_data, out_valid, out_phase
  );

  modport slave (
    input  in_valid, in_i, in_q, sync, mode,
    output out_data, out_valid, out_phase
  );
endinterface

// File: rtl/ddsm_fs4_duc.sv
// ddsm_fs4_duc: fs/4 quadrature digital up-converter for DDSM I/Q words.
// Output sequence over phases 0..3 is I, Q, -I, -Q (negation saturating).
// Two registered stages: capture (s1) then mix (out). in_valid -> out_valid
// latency is 2 cycles, one sample per clock, no backpressure.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ddsm_fs4_duc_if slave (in_valid/in_i/in_q/sync/mode in,
//          out_data/out_valid/out_phase out)
module ddsm_fs4_duc #(
  parameter int DW      = 6,
  parameter int PH_INIT = 0
) (
  input logic           clk,
  input logic           rst,
  ddsm_fs4_duc_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_MIX   = 2'b00,
    MODE_IPASS = 2'b01,
    MODE_TONE  = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  typedef struct packed {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    mode_e                mode;
    logic [1:0]           ph;
  } s1_t;

  localparam logic [1:0]           PH0   = 2'(PH_INIT);
  localparam logic signed [DW-1:0] MAXV  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] NMAXV = -MAXV;

  // vld_pipe_q[0] = stage-1 valid, vld_pipe_q[1] = out_valid
  logic [1:0]           vld_pipe_q;
  s1_t                  s1_q, s1_d;
  logic [1:0]           phase_q, phase_d;
  logic signed [DW-1:0] out_data_q, mix_d;
  logic [1:0]           out_phase_q;

  logic signed [DW-1:0] sel_s, neg_s;
  logic signed [DW:0]   neg_w;

  // Phase counter: sync wins over advance; a sample coinciding with sync
  // is still captured with the pre-sync phase.
  always_comb begin
    phase_d = phase_q;
    if (bus.sync)          phase_d = PH0;
    else if (bus.in_valid) phase_d = phase_q + 2'd1;
  end

  always_comb begin
    s1_d = s1_q;
    if (bus.in_valid) begin
      s1_d.i    = bus.in_i;
      s1_d.q    = bus.in_q;
      s1_d.mode = mode_e'(bus.mode);
      s1_d.ph   = phase_q;
    end
  end

  // Odd phases pick Q, even pick I; phases 2/3 use the negated word.
  // Negation is done one bit wider; the only value that does not fit back
  // into DW bits is +2^(DW-1) (from the most negative input), detected by
  // the top two bits disagreeing, and clamped to +max.
  always_comb begin
    sel_s = s1_q.ph[0] ? s1_q.q : s1_q.i;
    neg_w = -{sel_s[DW-1], sel_s};
    neg_s = (neg_w[DW] != neg_w[DW-1]) ? MAXV : neg_w[DW-1:0];
    mix_d = '0;
    case (s1_q.mode)
      MODE_MIX:   mix_d = s1_q.ph[1] ? neg_s : sel_s;
      MODE_IPASS: mix_d = s1_q.i;
      MODE_TONE: begin
        if (s1_q.ph == 2'd0)      mix_d = MAXV;
        else if (s1_q.ph == 2'd2) mix_d = NMAXV;
        else                      mix_d = '0;
      end
      MODE_MUTE:  mix_d = '0;
      default:    mix_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH0;
      s1_q        <= '0;
      vld_pipe_q  <= '0;
      out_data_q  <= '0;
      out_phase_q <= '0;
    end else begin
      phase_q    <= phase_d;
      s1_q       <= s1_d;
      vld_pipe_q <= {vld_pipe_q[0], bus.in_valid};
      // Output data/phase hold across invalid cycles.
      if (vld_pipe_q[0]) begin
        out_data_q  <= mix_d;
        out_phase_q <= s1_q.ph;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = vld_pipe_q[1];
  assign bus.out_phase = out_phase_q;

endmodule

// File: tb/tb_ddsm_fs4_duc.sv
// tb_ddsm_fs4_duc: self-checking bench for ddsm_fs4_duc (DW=6, PH_INIT=0).
// A behavioural model tracks the phase index and the expected output of
// each captured sample using plain integer arithmetic; scenario tasks also
// check the literal sequences expected for their stimulus.
module tb_ddsm_fs4_duc;
  localparam int DW   = 6;
  localparam int MAXI = (1 << (DW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ddsm_fs4_duc_if #(.DW(DW)) bus ();

  ddsm_fs4_duc #(.DW(DW), .PH_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: current phase, sample waiting to come out, visible output.
  int m_ph;
  bit p_v;  int p_d;  int p_ph;
  bit o_v;  int o_d;  int o_ph;

  function automatic int neg_sat(int x);
    return (-x > MAXI) ? MAXI : -x;
  endfunction

  function automatic int ref_sample(int mode, int ph, int i, int q);
    case (mode)
      0: case (ph)
           0: return i;
           1: return q;
           2: return neg_sat(i);
           default: return neg_sat(q);
         endcase
      1: return i;
      2: return (ph == 0) ? MAXI : ((ph == 2) ? -MAXI : 0);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0;
    p_v = 0; p_d = 0; p_ph = 0;
    o_v = 0; o_d = 0; o_ph = 0;
  endtask

  function automatic int dut_data();
    return int'($signed(bus.out_data));
  endfunction

  // Apply one cycle of stimulus, advance the model, settle past the edge.
  task automatic cyc(bit v, int i, int q, bit s, int m);
    bus.in_valid = v;
    bus.in_i     = DW'(i);
    bus.in_q     = DW'(q);
    bus.sync     = s;
    bus.mode     = 2'(m);
    @(posedge clk);
    o_v = p_v;
    if (p_v) begin o_d = p_d; o_ph = p_ph; end
    p_v = v;
    if (v) begin p_d = ref_sample(m, m_ph, i, q); p_ph = m_ph; end
    if (s)      m_ph = 0;
    else if (v) m_ph = (m_ph + 1) % 4;
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0;
    bus.sync = 1'b0; bus.mode = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(2 * MAXI + 1)) - (MAXI + 1);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.out_phase, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got v=%0b ph=%0d d=%0d want 0/0/0",
               bus.out_valid, bus.out_phase, dut_data());
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) cyc(1'b1, rnd_s(), rnd_s(), 1'b0, 0);
    // asynchronous reset in the middle of a clock period
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({bus.out_valid, bus.out_phase, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b ph=%0d d=%0d want 0/0/0",
               bus.out_valid, bus.out_phase, dut_data());
    end
    rst = 1'b0;
    cyc(1'b1, 17, -3, 1'b0, 0);
    cyc(1'b0, 0, 0, 1'b0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_phase !== 2'd0 || dut_data() !== 17) begin
      errors++;
      $display("FAIL reset_first: got v=%0b ph=%0d d=%0d want 1/0/17",
               bus.out_valid, bus.out_phase, dut_data());
    end
  endtask

  task automatic test_normal_mix();
    int seq[4] = '{12, -8, -12, 8};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 12, -8, 1'b0, 0);
      checks++;
      if ({bus.out_valid, bus.out_phase, bus.out_data} !== {o_v, 2'(o_ph), DW'(o_d)}) begin
        errors++;
        $display("FAIL mix_model k=%0d: got v=%0b ph=%0d d=%0d want v=%0b ph=%0d d=%0d",
                 k, bus.out_valid, bus.out_phase, dut_data(), o_v, o_ph, o_d);
      end
      if (k >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_phase) !== (k - 1) % 4 ||
            dut_data() !== seq[(k - 1) % 4]) begin
          errors++;
          $display("FAIL mix_seq k=%0d: got v=%0b ph=%0d d=%0d want 1/%0d/%0d",
                   k, bus.out_valid, bus.out_phase, dut_data(), (k - 1) % 4, seq[(k - 1) % 4]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int sat[4] = '{-32, -32, 31, 31};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, -32, -32, 1'b0, 0);
      if (k >= 1) begin
        checks++;
        if (dut_data() !== sat[k - 1] || int'(bus.out_phase) !== k - 1) begin
          errors++;
          $display("FAIL sat k=%0d: got ph=%0d d=%0d want ph=%0d d=%0d",
                   k, bus.out_phase, dut_data(), k - 1, sat[k - 1]);
        end
      end
    end
  endtask

  task automatic test_valid_gaps();
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int nseen = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bit v;
      v = (k < 7) ? pat[k] : 1'b0;
      cyc(v, k + 1, -(k + 1), 1'b0, 0);
      checks++;
      if ({bus.out_valid, bus.out_phase, bus.out_data} !== {o_v, 2'(o_ph), DW'(o_d)}) begin
        errors++;
        $display("FAIL gap_model k=%0d: got v=%0b ph=%0d d=%0d want v=%0b ph=%0d d=%0d",
                 k, bus.out_valid, bus.out_phase, dut_data(), o_v, o_ph, o_d);
      end
      if (k >= 1) begin
        checks++;
        if (bus.out_valid !== pat[k - 1]) begin
          errors++;
          $display("FAIL gap_valid k=%0d: got %0b want %0b", k, bus.out_valid, pat[k - 1]);
        end
        if (bus.out_valid === 1'b1) begin
          checks++;
          if (int'(bus.out_phase) !== nseen) begin
            errors++;
            $display("FAIL gap_phase k=%0d: got %0d want %0d", k, bus.out_phase, nseen);
          end
          nseen++;
        end
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    cyc(1'b1, 5, 6, 1'b0, 0);
    cyc(1'b1, 7, 8, 1'b0, 0);
    cyc(1'b1, 9, 10, 1'b1, 0);
    cyc(1'b1, 11, 12, 1'b0, 0);
    checks++;
    if (bus.out_phase !== 2'd2 || dut_data() !== -9) begin
      errors++;
      $display("FAIL sync_at: got ph=%0d d=%0d want ph=2 d=-9", bus.out_phase, dut_data());
    end
    cyc(1'b0, 0, 0, 1'b0, 0);
    checks++;
    if (bus.out_phase !== 2'd0 || dut_data() !== 11) begin
      errors++;
      $display("FAIL sync_after: got ph=%0d d=%0d want ph=0 d=11", bus.out_phase, dut_data());
    end
  endtask

  task automatic test_modes();
    int exp_d[12];
    int tone[4] = '{31, 0, -31, 0};
    do_reset();
    for (int k = 0; k < 12; k++)
      exp_d[k] = (k < 4) ? tone[k] : ((k < 8) ? 0 : 20);
    for (int k = 0; k < 13; k++) begin
      int m;
      m = (k < 4) ? 2 : ((k < 8) ? 3 : 1);
      if (k < 12) cyc(1'b1, (k >= 8) ? 20 : rnd_s(), rnd_s(), 1'b0, m);
      else        cyc(1'b0, 0, 0, 1'b0, 0);
      if (k >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || dut_data() !== exp_d[k - 1]) begin
          errors++;
          $display("FAIL mode k=%0d: got v=%0b d=%0d want 1/%0d",
                   k, bus.out_valid, dut_data(), exp_d[k - 1]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 4) != 0, rnd_s(), rnd_s(), ($urandom % 16) == 0,
          ($urandom % 3 == 0) ? int'($urandom % 4) : 0);
      checks++;
      if ({bus.out_valid, bus.out_phase, bus.out_data} !== {o_v, 2'(o_ph), DW'(o_d)}) begin
        errors++;
        $display("FAIL rand k=%0d: got v=%0b ph=%0d d=%0d want v=%0b ph=%0d d=%0d",
                 k, bus.out_valid, bus.out_phase, dut_data(), o_v, o_ph, o_d);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_normal_mix();
    test_saturation();
    test_valid_gaps();
    test_sync();
    test_modes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddsm_fs4_duc.md
Name: ddsm_fs4_duc

Overview:
- Digital up-converter placed directly downstream of the I and Q delta-sigma modulators.
- Consumes the 6-bit two's-complement DDSM words for I and Q.
- Performs fs/4 quadrature up-conversion: the output sequence is I, Q, -I, -Q. The result is one real 6-bit stream for the RF DAC/PA driver.
- Adds a registered two-stage pipeline, a phase counter gated by valid, saturating negation, phase resync and a test mode.

Parameters:
- DW, 6, I/Q input and output sample width, two's complement.
- PH_INIT, 0, phase index (0..3) loaded on reset and on sync.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_i/in_q hold a new sample pair this cycle.
- in_i  input  DW  I-path DDSM word (signed).
- in_q  input  DW  Q-path DDSM word (signed).
- sync  input  1  forces the phase counter to PH_INIT on the next edge.
- mode  input  2  00 = normal fs/4 mix, 01 = I passthrough, 10 = constant +max tone test, 11 = output muted (zero).
- out_data  output  DW  up-converted sample (signed).
- out_valid  output  1  out_data is valid.
- out_phase  output  2  phase index used to produce out_data.

Behaviour:
- Reset (asynchronous, active-high): stage registers, out_data, out_valid and out_phase go to 0; the phase counter goes to PH_INIT. Reset takes effect immediately mid-stream; pending pipeline data is discarded.
- Stage 1 (capture): on in_valid=1, the block registers in_i, in_q, mode and the current phase into s1; s1_valid<=1. Otherwise s1_valid<=0 and the s1 data holds.
- Phase counter: 2-bit. It advances by 1 (wrapping 3->0) only on cycles with in_valid=1.
- Sync: sync=1 loads PH_INIT. Sync has priority over advance. If sync and in_valid coincide, the sample is captured with the pre-sync phase and the counter becomes PH_INIT, not PH_INIT+1.
- Stage 2 (mix), registered from s1, normal mode:
  - phase 0 -> I
  - phase 1 -> Q
  - phase 2 -> -I
  - phase 3 -> -Q
- Negation saturates: -(-2^(DW-1)) = 2^(DW-1)-1, i.e. -(-32) = +31 for DW=6. All other values are exact.
- mode 01: out = I at every phase; the phase still advances.
- mode 10: out = +max, 0, -max, 0 for phases 0..3; +31/0/-31/0 for DW=6; inputs ignored.
- mode 11: out = 0.
- Mode is sampled with the data in stage 1, so a mode change affects only samples captured after the change.
- Stage-2 outputs:
  - out_valid = s1_valid delayed one cycle.
  - out_phase = the captured phase.
  - When out_valid=0, out_data and out_phase hold their previous value.
- Latency: sample captured at edge N appears on out_data after edge N+1. in_valid to out_valid is 2 cycles. Full throughput of one sample per clock; no backpressure.
- Gaps in in_valid do not advance the phase. The output sequence is therefore continuous across gaps, with no phase slip.
- No internal arithmetic wider than DW+1 bits. The negation result is computed in DW+1 bits, then clamped.

Test Plan:
- Reset: assert rst asynchronously mid-stream -> out_data=0, out_valid=0, out_phase=0 immediately. After release, the first sample uses phase PH_INIT=0.
- Normal mix: in_valid=1 continuously with in_i=12, in_q=-8 -> from cycle 2, out_data = 12, -8, -12, 8 repeating, out_phase = 0,1,2,3, out_valid=1.
- Saturation: in_i=-32, in_q=-32 -> phases 2 and 3 output +31; phases 0 and 1 output -32.
- Valid gaps: in_valid pattern 1,0,0,1,1,0,1 with distinct I/Q values -> out_phase on valid outputs is 0,1,2,3 consecutively and out_valid mirrors the pattern delayed 2 cycles.
- Sync: at phase 2, pulse sync with in_valid=1 -> that sample uses phase 2; the next valid sample uses phase 0.
- Modes: mode=10 -> out_data = 31, 0, -31, 0 regardless of input. Switch to 11 -> out_data=0 two cycles later. Switch to 01 with in_i=20 -> out_data=20 at every phase.
